mem_port_arbiter: RTL and testbench

Shares the single 128-bit memory port between the read-only instruction cache and the read/write data cache of the 5-stage RV32IC pipeline. The arbiter grants one cache miss or write-back at a time and drives the memory request from registers. It routes `mem_ready` back to the granted cache only, and counts per-client wait cycles for performance debug. It sits between both caches' `mem_*` ports and the memory model/controller.

---
 rtl/mem_port_arbiter.sv | 125 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbiter that shares the single 128-bit memory port between the I-cache and the D-cache.
// It issues one registered request at a time and counts per-client wait cycles.
module mem_port_arbiter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             proc_reset,
  input  logic             i_mem_read,
  input  logic [27:0]      i_mem_addr,
  output logic [127:0]     i_mem_rdata,
  output logic             i_mem_ready,
  input  logic             d_mem_read,
  input  logic             d_mem_write,
  input  logic [27:0]      d_mem_addr,
  input  logic [127:0]     d_mem_wdata,
  output logic [127:0]     d_mem_rdata,
  output logic             d_mem_ready,
  output logic             mem_read,
  output logic             mem_write,
  output logic [27:0]      mem_addr,
  output logic [127:0]     mem_wdata,
  input  logic [127:0]     mem_rdata,
  input  logic             mem_ready,
  output logic [CNT_W-1:0] i_wait_cnt,
  output logic [CNT_W-1:0] d_wait_cnt
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] BUSY_I = 2'd1;
  localparam logic [1:0] BUSY_D = 2'd2;
  localparam logic [1:0] GAP    = 2'd3;

  logic [1:0]       r_state;
  logic             r_last_d;
  logic             r_mem_read;
  logic             r_mem_write;
  logic [27:0]      r_mem_addr;
  logic [127:0]     r_mem_wdata;
  logic [CNT_W-1:0] r_i_wait;
  logic [CNT_W-1:0] r_d_wait;

  logic w_i_req;
  logic w_d_req;
  logic w_grant_i;
  logic w_grant_d;

  assign w_i_req   = i_mem_read;
  assign w_d_req   = d_mem_read | d_mem_write;
  // On a tie the client not served last wins; r_last_d=1 means the D-cache was last.
  assign w_grant_i = w_i_req & (~w_d_req | r_last_d);
  assign w_grant_d = w_d_req & ~w_grant_i;

  always_ff @(posedge clk) begin
    if (proc_reset) begin
      r_state     <= IDLE;
      r_last_d    <= 1'b1;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_grant_i) begin
            r_state     <= BUSY_I;
            r_last_d    <= 1'b0;
            r_mem_read  <= 1'b1;
            r_mem_write <= 1'b0;
            r_mem_addr  <= i_mem_addr;
            r_mem_wdata <= '0;
          end else if (w_grant_d) begin
            // A simultaneous read+write from the D-cache is issued as a write only.
            r_state     <= BUSY_D;
            r_last_d    <= 1'b1;
            r_mem_read  <= d_mem_read & ~d_mem_write;
            r_mem_write <= d_mem_write;
            r_mem_addr  <= d_mem_addr;
            r_mem_wdata <= d_mem_wdata;
          end
        end
        BUSY_I, BUSY_D: begin
          if (mem_ready || (r_state == BUSY_I ? !w_i_req : !w_d_req)) begin
            r_state     <= GAP;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_mem_read  <= 1'b0;
          r_mem_write <= 1'b0;
          r_mem_addr  <= '0;
          r_mem_wdata <= '0;
        end
      endcase
    end
  end

  // Wait counters saturate at all-ones and only reset clears them.
  always_ff @(posedge clk) begin
    if (proc_reset) begin
      r_i_wait <= '0;
      r_d_wait <= '0;
    end else begin
      if (w_i_req && (r_state != BUSY_I) && (r_i_wait != '1))
        r_i_wait <= r_i_wait + CNT_W'(1);
      if (w_d_req && (r_state != BUSY_D) && (r_d_wait != '1))
        r_d_wait <= r_d_wait + CNT_W'(1);
    end
  end

  assign i_mem_ready = (r_state == BUSY_I) & mem_ready;
  assign d_mem_ready = (r_state == BUSY_D) & mem_ready;
  assign i_mem_rdata = mem_rdata;
  assign d_mem_rdata = mem_rdata;
  assign mem_read    = r_mem_read;
  assign mem_write   = r_mem_write;
  assign mem_addr    = r_mem_addr;
  assign mem_wdata   = r_mem_wdata;
  assign i_wait_cnt  = r_i_wait;
  assign d_wait_cnt  = r_d_wait;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter; issued memory requests are matched
// against a queue of expected transactions filled as the clients request.
module tb_mem_port_arbiter;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             proc_reset;
  logic             i_mem_read;
  logic [27:0]      i_mem_addr;
  logic [127:0]     i_mem_rdata;
  logic             i_mem_ready;
  logic             d_mem_read;
  logic             d_mem_write;
  logic [27:0]      d_mem_addr;
  logic [127:0]     d_mem_wdata;
  logic [127:0]     d_mem_rdata;
  logic             d_mem_ready;
  logic             mem_read;
  logic             mem_write;
  logic [27:0]      mem_addr;
  logic [127:0]     mem_wdata;
  logic [127:0]     mem_rdata;
  logic             mem_ready;
  logic [CNT_W-1:0] i_wait_cnt;
  logic [CNT_W-1:0] d_wait_cnt;

  typedef struct packed {
    logic         wr;
    logic         rd;
    logic [27:0]  addr;
    logic [127:0] wdata;
  } txn_t;

  txn_t expQ[$];
  int   checkCount = 0;
  int   failCount  = 0;
  logic prevActive = 1'b0;

  localparam logic [127:0] WDATA_A = 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF;
  localparam logic [127:0] WDATA_B = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
  localparam logic [127:0] RDATA_A = 128'hCAFE_F00D_0000_1111_2222_3333_4444_5555;

  mem_port_arbiter #(.CNT_W(CNT_W)) dut (
    .clk         (clk),
    .proc_reset  (proc_reset),
    .i_mem_read  (i_mem_read),
    .i_mem_addr  (i_mem_addr),
    .i_mem_rdata (i_mem_rdata),
    .i_mem_ready (i_mem_ready),
    .d_mem_read  (d_mem_read),
    .d_mem_write (d_mem_write),
    .d_mem_addr  (d_mem_addr),
    .d_mem_wdata (d_mem_wdata),
    .d_mem_rdata (d_mem_rdata),
    .d_mem_ready (d_mem_ready),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mem_ready   (mem_ready),
    .i_wait_cnt  (i_wait_cnt),
    .d_wait_cnt  (d_wait_cnt)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checkCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock; afterwards registered outputs are settled and inputs may change.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic applyStimulus(input logic ir, input logic [27:0] ia,
                               input logic dr, input logic dw, input logic [27:0] da,
                               input logic [127:0] dwd);
    i_mem_read  = ir;
    i_mem_addr  = ia;
    d_mem_read  = dr;
    d_mem_write = dw;
    d_mem_addr  = da;
    d_mem_wdata = dwd;
  endtask

  task automatic pushTxn(input logic wr, input logic rd, input logic [27:0] addr, input logic [127:0] wdata);
    txn_t t;
    t.wr = wr; t.rd = rd; t.addr = addr; t.wdata = wdata;
    expQ.push_back(t);
  endtask

  task automatic checkMemIdle(input string tag);
    checkOutput({tag, "_rd"},    128'(mem_read),  128'(0));
    checkOutput({tag, "_wr"},    128'(mem_write), 128'(0));
    checkOutput({tag, "_addr"},  128'(mem_addr),  128'(0));
    checkOutput({tag, "_wdata"}, mem_wdata,       128'(0));
  endtask

  task automatic checkReadies(input string tag, input logic iExp, input logic dExp);
    #1;
    checkOutput({tag, "_iready"}, 128'(i_mem_ready), 128'(iExp));
    checkOutput({tag, "_dready"}, 128'(d_mem_ready), 128'(dExp));
  endtask

  // Scoreboard: each new memory request is compared with the oldest expected transaction.
  always @(negedge clk) begin
    if ((mem_read || mem_write) && !prevActive) begin
      checkOutput("txn_expected", 128'(expQ.size() > 0), 128'(1));
      if (expQ.size() > 0) begin
        txn_t t;
        t = expQ.pop_front();
        checkOutput("txn_wr",    128'(mem_write), 128'(t.wr));
        checkOutput("txn_rd",    128'(mem_read),  128'(t.rd));
        checkOutput("txn_addr",  128'(mem_addr),  128'(t.addr));
        checkOutput("txn_wdata", mem_wdata,       t.wdata);
      end
    end
    prevActive <= mem_read | mem_write;
  end

  initial begin
    proc_reset = 1'b1;
    mem_ready  = 1'b0;
    mem_rdata  = '0;
    applyStimulus(1'b0, 28'h0, 1'b0, 1'b0, 28'h0, '0);
    tick(); tick();
    proc_reset = 1'b0;
    checkMemIdle("reset");
    checkOutput("reset_iwait", 128'(i_wait_cnt), 128'(0));
    checkOutput("reset_dwait", 128'(d_wait_cnt), 128'(0));

    // I-cache only fill, memory answers on the 4th BUSY cycle.
    applyStimulus(1'b1, 28'h0000040, 1'b0, 1'b0, 28'h0, '0);
    pushTxn(1'b0, 1'b1, 28'h0000040, '0);
    tick();
    checkOutput("ionly_rd",   128'(mem_read), 128'(1));
    checkOutput("ionly_addr", 128'(mem_addr), 128'(28'h0000040));
    checkReadies("ionly_wait", 1'b0, 1'b0);
    tick(); tick(); tick();
    checkOutput("ionly_hold", 128'(mem_read), 128'(1));
    mem_ready = 1'b1;
    mem_rdata = RDATA_A;
    checkReadies("ionly_done", 1'b1, 1'b0);
    checkOutput("ionly_rdata", i_mem_rdata, RDATA_A);
    tick();
    mem_ready = 1'b0;
    applyStimulus(1'b0, 28'h0, 1'b0, 1'b0, 28'h0, '0);
    checkMemIdle("ionly_gap");
    checkOutput("ionly_iwait", 128'(i_wait_cnt), 128'(1));
    tick();

    // Tie right after reset: I-cache first, D-cache write three cycles after mem_ready.
    proc_reset = 1'b1;
    tick();
    proc_reset = 1'b0;
    applyStimulus(1'b1, 28'h0000080, 1'b0, 1'b1, 28'h0000100, WDATA_A);
    pushTxn(1'b0, 1'b1, 28'h0000080, '0);
    pushTxn(1'b1, 1'b0, 28'h0000100, WDATA_A);
    tick();
    checkOutput("tie1_igrant", 128'(mem_addr), 128'(28'h0000080));
    tick();
    mem_ready = 1'b1;
    checkReadies("tie1_idone", 1'b1, 1'b0);
    tick();
    mem_ready = 1'b0;
    i_mem_read = 1'b0;
    checkMemIdle("tie1_gap");
    tick();
    checkOutput("tie1_idle_wr", 128'(mem_write), 128'(0));
    tick();
    checkOutput("tie1_dgrant_wr", 128'(mem_write), 128'(1));
    checkOutput("tie1_dgrant_rd", 128'(mem_read), 128'(0));
    checkOutput("tie1_dgrant_wdata", mem_wdata, WDATA_A);
    checkOutput("tie1_dwait", 128'(d_wait_cnt), 128'(5));
    checkOutput("tie1_iwait", 128'(i_wait_cnt), 128'(1));
    mem_ready = 1'b1;
    checkReadies("tie1_ddone", 1'b0, 1'b1);
    tick();
    mem_ready = 1'b0;
    applyStimulus(1'b0, 28'h0, 1'b0, 1'b0, 28'h0, '0);
    tick();

    // Second tie: D-cache was served last, so the I-cache wins again.
    applyStimulus(1'b1, 28'h00000C0, 1'b1, 1'b0, 28'h0000200, WDATA_B);
    pushTxn(1'b0, 1'b1, 28'h00000C0, '0);
    pushTxn(1'b0, 1'b1, 28'h0000200, WDATA_B);
    tick();
    checkOutput("tie2_igrant", 128'(mem_addr), 128'(28'h00000C0));
    mem_ready = 1'b1;
    checkReadies("tie2_idone", 1'b1, 1'b0);
    tick();
    mem_ready = 1'b0;
    i_mem_read = 1'b0;
    tick(); tick();
    checkOutput("tie2_dgrant_rd", 128'(mem_read), 128'(1));
    checkOutput("tie2_dgrant_addr", 128'(mem_addr), 128'(28'h0000200));

    // Reset while BUSY_D: outputs and counters clear, late mem_ready is not forwarded.
    proc_reset = 1'b1;
    tick();
    proc_reset = 1'b0;
    applyStimulus(1'b0, 28'h0, 1'b0, 1'b0, 28'h0, '0);
    checkMemIdle("rst_busy");
    checkOutput("rst_busy_iwait", 128'(i_wait_cnt), 128'(0));
    checkOutput("rst_busy_dwait", 128'(d_wait_cnt), 128'(0));
    mem_ready = 1'b1;
    checkReadies("rst_late_ready", 1'b0, 1'b0);
    tick();
    mem_ready = 1'b0;
    checkOutput("rst_late_dwait", 128'(d_wait_cnt), 128'(0));

    // Saturation: D-cache waits behind a long I-cache fill.
    applyStimulus(1'b1, 28'h0000300, 1'b1, 1'b0, 28'h0000400, '0);
    pushTxn(1'b0, 1'b1, 28'h0000300, '0);
    pushTxn(1'b0, 1'b1, 28'h0000400, '0);
    for (int k = 1; k <= 20; k++) begin
      tick();
      checkOutput($sformatf("sat_dwait_%0d", k), 128'(d_wait_cnt), 128'((k > 15) ? 15 : k));
    end
    checkOutput("sat_igrant_held", 128'(mem_addr), 128'(28'h0000300));
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    i_mem_read = 1'b0;
    tick(); tick();
    checkOutput("sat_dgrant_addr", 128'(mem_addr), 128'(28'h0000400));
    checkOutput("sat_dwait_hold", 128'(d_wait_cnt), 128'(15));
    mem_ready = 1'b1;
    checkReadies("sat_ddone", 1'b0, 1'b1);
    tick();
    mem_ready = 1'b0;
    applyStimulus(1'b0, 28'h0, 1'b0, 1'b0, 28'h0, '0);
    tick();

    // Abort: I-cache drops its request, later mem_ready is ignored.
    applyStimulus(1'b1, 28'h0000500, 1'b0, 1'b0, 28'h0, '0);
    pushTxn(1'b0, 1'b1, 28'h0000500, '0);
    tick();
    checkOutput("abort_grant", 128'(mem_read), 128'(1));
    tick();
    i_mem_read = 1'b0;
    tick();
    checkMemIdle("abort_gap");
    mem_ready = 1'b1;
    checkReadies("abort_gap_ready", 1'b0, 1'b0);
    tick();
    checkReadies("abort_idle_ready", 1'b0, 1'b0);
    mem_ready = 1'b0;

    // Illegal D-cache read+write is issued as a write.
    applyStimulus(1'b0, 28'h0, 1'b1, 1'b1, 28'h0000600, WDATA_B);
    pushTxn(1'b1, 1'b0, 28'h0000600, WDATA_B);
    tick();
    checkOutput("illegal_wr", 128'(mem_write), 128'(1));
    checkOutput("illegal_rd", 128'(mem_read), 128'(0));
    mem_ready = 1'b1;
    checkReadies("illegal_done", 1'b0, 1'b1);
    tick();
    mem_ready = 1'b0;
    applyStimulus(1'b0, 28'h0, 1'b0, 1'b0, 28'h0, '0);
    tick(); tick();

    checkOutput("queue_drained", 128'(expQ.size()), 128'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
